// File: rtl/mic_mem_responder.sv
// Word-access memory responder with a fixed-latency opcode fetch port.
// The word port is a small IDLE/WAIT/RESP machine; the fetch port reads storage every cycle.
module mic_mem_responder #(
  parameter int WORD       = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_req,
  input  logic            wr_req,
  input  logic [31:0]     mem_addr,
  input  logic [WORD-1:0] mem_out,
  input  logic            fetch_req,
  input  logic [31:0]     pc_addr,
  output logic [WORD-1:0] mem_in,
  output logic            rd_valid,
  output logic            wr_done,
  output logic [7:0]      fetch_data,
  output logic            fetch_valid,
  output logic            busy,
  output logic            err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  logic [1:0]            state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [WORD-1:0]       data_q, data_d;
  logic                  is_wr_q, is_wr_d;
  logic                  oor_q, oor_d;
  logic [WORD-1:0]       mem_in_q, mem_in_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_done_q, wr_done_d;
  logic                  err_q, err_d;
  logic [7:0]            fetch_data_q, fetch_data_d;
  logic                  fetch_valid_q;

  logic [WORD-1:0]       storage_q [2**DEPTH_LOG2];
  logic [WORD-1:0]       fetch_word;
  logic [7:0]            fetch_byte;
  logic                  fetch_oor;

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    is_wr_d    = is_wr_q;
    oor_d      = oor_q;
    mem_in_d   = mem_in_q;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req ^ wr_req) begin
          addr_d  = mem_addr[DEPTH_LOG2-1:0];
          data_d  = mem_out;
          is_wr_d = wr_req;
          oor_d   = |mem_addr[31:DEPTH_LOG2];
          if (WAIT > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT;
          end else begin
            state_d = ST_RESP;
          end
        end else if (rd_req && wr_req) begin
          err_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        err_d   = oor_q;
        if (is_wr_q) begin
          wr_done_d = ~oor_q;
        end else begin
          rd_valid_d = 1'b1;
          mem_in_d   = oor_q ? '0 : storage_q[addr_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Big-endian byte lane: byte offset 0 is the most significant byte of the word.
  always_comb begin
    fetch_word = storage_q[pc_addr[DEPTH_LOG2+1:2]];
    fetch_oor  = |pc_addr[31:DEPTH_LOG2+2];
    case (pc_addr[1:0])
      2'd0:    fetch_byte = fetch_word[WORD-1  -: 8];
      2'd1:    fetch_byte = fetch_word[WORD-9  -: 8];
      2'd2:    fetch_byte = fetch_word[WORD-17 -: 8];
      default: fetch_byte = fetch_word[WORD-25 -: 8];
    endcase
    fetch_data_d = fetch_data_q;
    if (fetch_req) fetch_data_d = fetch_oor ? 8'h00 : fetch_byte;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      addr_q        <= '0;
      data_q        <= '0;
      is_wr_q       <= 1'b0;
      oor_q         <= 1'b0;
      mem_in_q      <= '0;
      rd_valid_q    <= 1'b0;
      wr_done_q     <= 1'b0;
      err_q         <= 1'b0;
      fetch_data_q  <= 8'h00;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      is_wr_q       <= is_wr_d;
      oor_q         <= oor_d;
      mem_in_q      <= mem_in_d;
      rd_valid_q    <= rd_valid_d;
      wr_done_q     <= wr_done_d;
      err_q         <= err_d;
      fetch_data_q  <= fetch_data_d;
      fetch_valid_q <= fetch_req;
    end
  end

  // NOTE: storage has no reset so contents survive it; reset aborts a commit via state_q.
  always_ff @(posedge clk) begin
    if (state_q == ST_RESP && is_wr_q && !oor_q) storage_q[addr_q] <= data_q;
  end

  assign mem_in      = mem_in_q;
  assign rd_valid    = rd_valid_q;
  assign wr_done     = wr_done_q;
  assign err         = err_q;
  assign fetch_data  = fetch_data_q;
  assign fetch_valid = fetch_valid_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
